reg_file: RTL

Architectural register file with per-register rename tags: 32 × 32-bit integer registers, each holding a committed value and the ROB id of the youngest in-flight producer. Sits downstream of the reorder buffer and consumes its in-order commit stream (`reg_file_*`) and its `flush_outputs` pulse. The decoder writes rename tags at issue and reads two source operands per cycle. Each read returns either a ready value (tag 0) or the ROB id to wait on.

---
 rtl/reg_file_pkg.sv | 26 ++
 rtl/reg_file_read_port.sv | 38 +++
 rtl/reg_file.sv | 90 +++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reg_file_pkg : shared widths and types for the register file       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package reg_file_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_W    = 5;
  localparam int ROB_W    = 5;

  typedef logic [XLEN-1:0]  word_t;
  typedef logic [REG_W-1:0] reg_id_t;
  typedef logic [ROB_W-1:0] rob_id_t;

  localparam reg_id_t REG_ZERO = '0;
  localparam rob_id_t ROB_NONE = '0;

  // A commit only retires the tag if it is still the youngest producer.
  function automatic logic commit_owns_tag(rob_id_t cur_tag, rob_id_t commit_rob);
    return cur_tag == commit_rob;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_read_port.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reg_file_read_port : combinational operand lookup with x0 forcing  |
// | and same-cycle commit bypass. Rev 1.0                              |
// +--------------------------------------------------------------------+
module reg_file_read_port
  import reg_file_pkg::*;
(
  input  logic [REG_W-1:0] rs_id,
  input  logic [XLEN-1:0]  value_arr [NUM_REGS],
  input  logic [ROB_W-1:0] tag_arr   [NUM_REGS],
  input  logic             bypass_en,
  input  logic [REG_W-1:0] commit_reg_id,
  input  logic [XLEN-1:0]  commit_data,
  input  logic [ROB_W-1:0] commit_rob_id,
  output logic [XLEN-1:0]  rs_value,
  output logic [ROB_W-1:0] rs_tag
);

  logic w_bypass_hit;

  always_comb begin
    w_bypass_hit = bypass_en && (rs_id == commit_reg_id)
                   && commit_owns_tag(tag_arr[rs_id], commit_rob_id);
    rs_value = '0;
    rs_tag   = ROB_NONE;
    if (rs_id != REG_ZERO) begin
      if (w_bypass_hit) begin
        rs_value = commit_data;
      end else begin
        rs_value = value_arr[rs_id];
        rs_tag   = tag_arr[rs_id];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reg_file : 32x32 architectural registers with rename tags, fed by  |
// | the ROB commit stream and flush. Rev 1.0                           |
// +--------------------------------------------------------------------+
module reg_file
  import reg_file_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             commit_enabled,
  input  logic [REG_W-1:0] commit_reg_id,
  input  logic [XLEN-1:0]  commit_data,
  input  logic [ROB_W-1:0] commit_rob_id,
  input  logic             flush,
  input  logic             rename_enabled,
  input  logic [REG_W-1:0] rename_reg_id,
  input  logic [ROB_W-1:0] rename_rob_id,
  input  logic [REG_W-1:0] rs1_id,
  input  logic [REG_W-1:0] rs2_id,
  output logic [XLEN-1:0]  rs1_value,
  output logic [XLEN-1:0]  rs2_value,
  output logic [ROB_W-1:0] rs1_tag,
  output logic [ROB_W-1:0] rs2_tag
);

  logic [XLEN-1:0]  value_q [NUM_REGS];
  logic [XLEN-1:0]  value_d [NUM_REGS];
  logic [ROB_W-1:0] tag_q   [NUM_REGS];
  logic [ROB_W-1:0] tag_d   [NUM_REGS];
  logic             w_bypass_en;

  // Gating with reset keeps reads at 0/0 while rst_in is low, even if a commit is presented.
  assign w_bypass_en = commit_enabled && rst_in;

  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    if (commit_enabled && (commit_reg_id != REG_ZERO)) begin
      value_d[commit_reg_id] = commit_data;
      if (commit_owns_tag(tag_q[commit_reg_id], commit_rob_id)) begin
        tag_d[commit_reg_id] = ROB_NONE;
      end
    end
    // Rename is applied after the commit clear so it wins on the same register.
    if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        tag_d[i] = ROB_NONE;
      end
    end else if (rename_enabled && (rename_reg_id != REG_ZERO)) begin
      tag_d[rename_reg_id] = rename_rob_id;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      value_q <= '{default: '0};
      tag_q   <= '{default: '0};
    end else begin
      value_q <= value_d;
      tag_q   <= tag_d;
    end
  end

  reg_file_read_port u_rd1 (
    .rs_id         (rs1_id),
    .value_arr     (value_q),
    .tag_arr       (tag_q),
    .bypass_en     (w_bypass_en),
    .commit_reg_id (commit_reg_id),
    .commit_data   (commit_data),
    .commit_rob_id (commit_rob_id),
    .rs_value      (rs1_value),
    .rs_tag        (rs1_tag)
  );

  reg_file_read_port u_rd2 (
    .rs_id         (rs2_id),
    .value_arr     (value_q),
    .tag_arr       (tag_q),
    .bypass_en     (w_bypass_en),
    .commit_reg_id (commit_reg_id),
    .commit_data   (commit_data),
    .commit_rob_id (commit_rob_id),
    .rs_value      (rs2_value),
    .rs_tag        (rs2_tag)
  );

endmodule
`default_nettype wire
